jesd204_rx_bringup_seq: RTL and testbench
=========================================

Name: jesd204_rx_bringup_seq

Overview:
Top-level bring-up sequencer for the JESD204 RX link layer. It drives per-link PHY reset, enables character alignment and releases per-lane CGS monitors in order, with a programmable timeout per phase and bounded automatic retry. It sits between the register map (cfg_*/status_*) and the per-lane PHY/CGS datapath, replacing free-running bring-up with a supervised one.

Parameters:
NUM_LANES, 4, number of RX lanes (1..32)
TIMEOUT_WIDTH, 16, width of the phase timeout counter and cfg_timeout
RESET_CYCLES, 8, cycles phy_reset is held asserted per attempt (>=1)
MAX_RETRIES, 3, failed attempts allowed before entering FAILED (0..255)

Ports:
clk  input  1  link clock
reset  input  1  asynchronous, active-high
cfg_enable  input  1  level; 0 forces RESET state, 1 allows bring-up
cfg_restart  input  1  single-cycle pulse; restarts from RESET and clears retry count
cfg_timeout  input  TIMEOUT_WIDTH  cycles allowed per WAIT_PHY/ALIGN/CGS phase; 0 means no timeout
cfg_lanes_disable  input  NUM_LANES  1 = lane ignored in all readiness checks
phy_reset  output  1  PHY reset request
phy_ready  input  NUM_LANES  per-lane PHY ready
phy_en_char_align  output  1  comma alignment enable
phy_char_aligned  input  NUM_LANES  per-lane alignment done
cgs_reset  output  NUM_LANES  per-lane CGS monitor reset
cgs_ready  input  NUM_LANES  per-lane CGS complete
link_up  output  1  all enabled lanes through CGS
status_state  output  3  current state encoding
status_retry_count  output  8  failed attempts since last restart
status_failed  output  1  sequencer in FAILED

Behaviour:
- Reset values: state=RESET, phy_reset=1, phy_en_char_align=0, cgs_reset=all ones, link_up=0, status_retry_count=0, status_failed=0, timer=0.
- All outputs registered; derived from next state so they change on the same edge as state.
- "All ok" for vector v: &(v | cfg_lanes_disable). All lanes disabled counts as ok.
- States/encoding: RESET=0, WAIT_PHY=1, ALIGN=2, CGS=3, DATA=4, FAILED=5.
- RESET: phy_reset=1, cgs_reset=all 1. Timer counts; after RESET_CYCLES cycles in RESET with cfg_enable=1 -> WAIT_PHY. cfg_enable=0 holds RESET, timer cleared.
- WAIT_PHY: phy_reset=0. All phy_ready ok -> ALIGN.
- ALIGN: phy_en_char_align=1. All phy_char_aligned ok -> CGS.
- CGS: phy_en_char_align=1; cgs_reset[i]=cfg_lanes_disable[i] (disabled lanes stay in reset). All cgs_ready ok -> DATA.
- DATA: link_up=1, phy_en_char_align=0, cgs_reset unchanged. Any enabled lane dropping phy_ready or cgs_ready -> counts as failure (retry path).
- Timeout: timer clears on every state entry, increments each cycle in WAIT_PHY/ALIGN/CGS; timer==cfg_timeout-1 with phase not complete, cfg_timeout!=0 -> failure. Completion on the same cycle as timeout wins.
- Failure: status_retry_count increments (saturate at 255); if new count > MAX_RETRIES -> FAILED, else -> RESET.
- FAILED: phy_reset=1, cgs_reset=all 1, status_failed=1; exits only on cfg_restart or cfg_enable=0 (both -> RESET).
- cfg_restart (any state): next state RESET, retry count cleared; has priority over failure and phase completion.
- cfg_enable=0 (any state): next state RESET, retry count cleared, no failure counted; lower priority than nothing else—equivalent to restart held.
- reset asserted mid-operation: all outputs to reset values immediately (asynchronous).
- status_state reflects registered state.

Test Plan:
- Nominal, NUM_LANES=4: phy_ready after 10 cycles, aligned after 32, cgs_ready after 32 -> phy_reset drops 8 cycles after cfg_enable, link_up=1, status_state=4, retry_count=0.
- Lane 2 never aligns, cfg_timeout=100 -> RESET re-entered after 100 cycles in ALIGN, retry_count 1,2,3, then 4th failure -> status_failed=1, state=5, phy_reset=1.
- Same as above with cfg_lanes_disable=4'b0100 -> link_up=1, cgs_reset[2] stays 1.
- In DATA drop cgs_ready[0] for one cycle -> state RESET next cycle, link_up=0, retry_count=1, re-bring-up succeeds.
- cfg_restart pulsed in FAILED and on a timeout cycle -> RESET, retry_count=0, no increment.
- Async reset asserted mid-CGS between edges -> outputs at reset values before next clock edge; cfg_timeout=0 -> no timeout with stuck lane.

Source files
------------

// File: rtl/jesd204_rx_bringup_seq.sv
// rtl/jesd204_rx_bringup_seq.sv - JESD204 RX bring-up sequencer: PHY reset, char align, CGS release, timeout and retry
module jesd204_rx_bringup_seq #(
  parameter int NUM_LANES     = 4,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int RESET_CYCLES  = 8,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_enable,
  input  logic                     cfg_restart,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  input  logic [NUM_LANES-1:0]     cfg_lanes_disable,
  output logic                     phy_reset,
  input  logic [NUM_LANES-1:0]     phy_ready,
  output logic                     phy_en_char_align,
  input  logic [NUM_LANES-1:0]     phy_char_aligned,
  output logic [NUM_LANES-1:0]     cgs_reset,
  input  logic [NUM_LANES-1:0]     cgs_ready,
  output logic                     link_up,
  output logic [2:0]               status_state,
  output logic [7:0]               status_retry_count,
  output logic                     status_failed
);

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_WAIT_PHY = 3'd1,
    ST_ALIGN    = 3'd2,
    ST_CGS      = 3'd3,
    ST_DATA     = 3'd4,
    ST_FAILED   = 3'd5
  } state_t;

  // One counter serves both the reset hold and the phase timeout.
  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam int CW  = (TIMEOUT_WIDTH > RCW) ? TIMEOUT_WIDTH : RCW;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   timer;
  logic [CW-1:0]   timer_nxt;
  logic [CW-1:0]   timeout_ext;
  logic [7:0]      retry_nxt;
  logic [7:0]      retry_inc;
  logic            phy_ok;
  logic            align_ok;
  logic            cgs_ok;
  logic            phase_done;
  logic            timed_out;
  logic            fail;

  assign phy_ok      = &(phy_ready | cfg_lanes_disable);
  assign align_ok    = &(phy_char_aligned | cfg_lanes_disable);
  assign cgs_ok      = &(cgs_ready | cfg_lanes_disable);
  assign timeout_ext = CW'(cfg_timeout);
  assign timed_out   = (cfg_timeout != '0) && (timer == timeout_ext - CW'(1));
  assign retry_inc   = (status_retry_count == 8'hFF) ? 8'hFF : status_retry_count + 8'd1;
  assign status_state = state;

  always_comb begin
    phase_done = 1'b0;
    case (state)
      ST_WAIT_PHY: phase_done = phy_ok;
      ST_ALIGN:    phase_done = align_ok;
      ST_CGS:      phase_done = cgs_ok;
      default:     phase_done = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    retry_nxt = status_retry_count;
    fail      = 1'b0;
    if (!cfg_enable || cfg_restart) begin
      state_nxt = ST_RESET;
      timer_nxt = '0;
      retry_nxt = 8'd0;
    end else begin
      case (state)
        ST_RESET: begin
          if (timer == CW'(RESET_CYCLES - 1)) begin
            state_nxt = ST_WAIT_PHY;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + CW'(1);
          end
        end
        ST_WAIT_PHY, ST_ALIGN, ST_CGS: begin
          // Completion is checked first so it wins over a same-cycle timeout.
          if (phase_done) begin
            timer_nxt = '0;
            case (state)
              ST_WAIT_PHY: state_nxt = ST_ALIGN;
              ST_ALIGN:    state_nxt = ST_CGS;
              default:     state_nxt = ST_DATA;
            endcase
          end else if (timed_out) begin
            fail = 1'b1;
          end else begin
            timer_nxt = timer + CW'(1);
          end
        end
        ST_DATA: begin
          if (!phy_ok || !cgs_ok) begin
            fail = 1'b1;
          end
        end
        ST_FAILED: begin
          state_nxt = ST_FAILED;
        end
        default: begin
          state_nxt = ST_RESET;
          timer_nxt = '0;
        end
      endcase
      if (fail) begin
        retry_nxt = retry_inc;
        timer_nxt = '0;
        state_nxt = (int'(retry_inc) > MAX_RETRIES) ? ST_FAILED : ST_RESET;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= ST_RESET;
      timer              <= '0;
      status_retry_count <= 8'd0;
      phy_reset          <= 1'b1;
      phy_en_char_align  <= 1'b0;
      cgs_reset          <= '1;
      link_up            <= 1'b0;
      status_failed      <= 1'b0;
    end else begin
      state              <= state_nxt;
      timer              <= timer_nxt;
      status_retry_count <= retry_nxt;
      phy_reset          <= (state_nxt == ST_RESET) || (state_nxt == ST_FAILED);
      phy_en_char_align  <= (state_nxt == ST_ALIGN) || (state_nxt == ST_CGS);
      // Disabled lanes keep their CGS monitor in reset once the others are released.
      cgs_reset          <= ((state_nxt == ST_CGS) || (state_nxt == ST_DATA)) ? cfg_lanes_disable : '1;
      link_up            <= (state_nxt == ST_DATA);
      status_failed      <= (state_nxt == ST_FAILED);
    end
  end

endmodule

// File: tb/tb_jesd204_rx_bringup_seq.sv
// tb/tb_jesd204_rx_bringup_seq.sv - self-checking bench for jesd204_rx_bringup_seq
module tb_jesd204_rx_bringup_seq;

  localparam int NL = 4;
  localparam int TW = 16;
  localparam int RC = 8;
  localparam int MR = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_enable = 1'b0;
  logic          cfg_restart = 1'b0;
  logic [TW-1:0] cfg_timeout = '0;
  logic [NL-1:0] cfg_lanes_disable = '0;
  logic [NL-1:0] phy_ready = '0;
  logic [NL-1:0] phy_char_aligned = '0;
  logic [NL-1:0] cgs_ready = '0;
  logic          phy_reset;
  logic          phy_en_char_align;
  logic [NL-1:0] cgs_reset;
  logic          link_up;
  logic [2:0]    status_state;
  logic [7:0]    status_retry_count;
  logic          status_failed;

  jesd204_rx_bringup_seq #(
    .NUM_LANES(NL), .TIMEOUT_WIDTH(TW), .RESET_CYCLES(RC), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_restart(cfg_restart),
    .cfg_timeout(cfg_timeout), .cfg_lanes_disable(cfg_lanes_disable),
    .phy_reset(phy_reset), .phy_ready(phy_ready), .phy_en_char_align(phy_en_char_align),
    .phy_char_aligned(phy_char_aligned), .cgs_reset(cgs_reset), .cgs_ready(cgs_ready),
    .link_up(link_up), .status_state(status_state),
    .status_retry_count(status_retry_count), .status_failed(status_failed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase number, cycles spent in phase, failed attempts.
  int m_phase = 0;
  int m_age   = 0;
  int m_retry = 0;

  function automatic bit all_ok(input logic [NL-1:0] v);
    for (int i = 0; i < NL; i++)
      if (!v[i] && !cfg_lanes_disable[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_done();
    case (m_phase)
      1: return all_ok(phy_ready);
      2: return all_ok(phy_char_aligned);
      3: return all_ok(cgs_ready);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    m_phase = 0; m_age = 0; m_retry = 0;
  endtask

  task automatic model_fail();
    m_retry = (m_retry < 255) ? m_retry + 1 : 255;
    m_phase = (m_retry > MR) ? 5 : 0;
    m_age   = 0;
  endtask

  task automatic model_step();
    if (reset || !cfg_enable || cfg_restart) begin
      model_clear();
    end else begin
      case (m_phase)
        0: if (m_age + 1 >= RC) begin m_phase = 1; m_age = 0; end else m_age++;
        1, 2, 3: begin
          if (m_done()) begin m_phase++; m_age = 0; end
          else if (cfg_timeout != 0 && m_age + 1 == int'(cfg_timeout)) model_fail();
          else m_age++;
        end
        4: if (!all_ok(phy_ready) || !all_ok(cgs_ready)) model_fail();
        default: ;
      endcase
    end
  endtask

  // Lane environment: each lane responds a fixed number of cycles after its phase opens.
  int d_phy[NL], d_al[NL], d_cgs[NL];
  int t_phy = 0, t_al = 0;
  int t_cgs[NL];
  logic [NL-1:0] stuck = '0;
  logic [NL-1:0] drop  = '0;

  task automatic drive();
    for (int i = 0; i < NL; i++) begin
      phy_ready[i]        = (t_phy >= d_phy[i]);
      phy_char_aligned[i] = !stuck[i] && (t_al >= d_al[i]);
      cgs_ready[i]        = (t_cgs[i] >= d_cgs[i]) && !drop[i];
    end
  endtask

  task automatic env_update();
    t_phy = phy_reset ? 0 : t_phy + 1;
    t_al  = phy_en_char_align ? t_al + 1 : 0;
    for (int i = 0; i < NL; i++) t_cgs[i] = cgs_reset[i] ? 0 : t_cgs[i] + 1;
    drive();
  endtask

  task automatic compare();
    logic [NL-1:0] e_cgs;
    e_cgs = (m_phase == 3 || m_phase == 4) ? cfg_lanes_disable : '1;
    check("state", status_state, m_phase);
    check("phy_reset", phy_reset, (m_phase == 0 || m_phase == 5));
    check("char_align", phy_en_char_align, (m_phase == 2 || m_phase == 3));
    check("cgs_reset", cgs_reset, e_cgs);
    check("link_up", link_up, (m_phase == 4));
    check("retry", status_retry_count, m_retry);
    check("failed", status_failed, (m_phase == 5));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    env_update();
    compare();
  endtask

  task automatic pulse_restart();
    cfg_restart = 1'b1;
    tick();
    cfg_restart = 1'b0;
  endtask

  task automatic run_until(input int ph, input int budget, input string tag);
    int n = 0;
    while (status_state != ph && n < budget) begin tick(); n++; end
    check(tag, status_state, ph);
  endtask

  task automatic set_delays(input int p, input int a, input int c);
    for (int i = 0; i < NL; i++) begin d_phy[i] = p; d_al[i] = a; d_cgs[i] = c; end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, status_state, 0);
    check({tag, "_phy_reset"}, phy_reset, 1);
    check({tag, "_align"}, phy_en_char_align, 0);
    check({tag, "_cgs_reset"}, cgs_reset, {NL{1'b1}});
    check({tag, "_link_up"}, link_up, 0);
    check({tag, "_retry"}, status_retry_count, 0);
    check({tag, "_failed"}, status_failed, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, dwell, found;
    for (int i = 0; i < NL; i++) t_cgs[i] = 0;
    set_delays(10, 32, 32);
    drive();
    #12;
    check_reset_values("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    env_update();

    // Nominal bring-up
    cfg_timeout = 16'd1000;
    cfg_enable  = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (lat < 0 && !phy_reset) lat = k;
    end
    check("phy_reset_latency", lat, RC);
    run_until(4, 300, "nominal_data");
    check("nominal_link_up", link_up, 1);
    check("nominal_retry", status_retry_count, 0);

    // Lane 2 never aligns: timeouts, retries, then FAILED
    stuck = 4'b0100;
    cfg_timeout = 16'd100;
    drive();
    pulse_restart();
    run_until(2, 100, "stuck_reach_align");
    dwell = 0;
    while (status_state == 2 && dwell < 300) begin tick(); dwell++; end
    check("align_dwell", dwell, 100);
    check("first_fail_retry", status_retry_count, 1);
    check("first_fail_state", status_state, 0);
    run_until(5, 2000, "stuck_to_failed");
    check("failed_flag", status_failed, 1);
    check("failed_retry", status_retry_count, MR + 1);
    check("failed_phy_reset", phy_reset, 1);

    // Restart from FAILED, then restart on an exact timeout cycle
    pulse_restart();
    check("restart_failed_state", status_state, 0);
    check("restart_failed_retry", status_retry_count, 0);
    found = 0;
    for (int k = 0; k < 500 && found == 0; k++) begin
      if (m_phase == 2 && m_age + 1 == int'(cfg_timeout) && !m_done()) begin
        pulse_restart();
        found = 1;
      end else begin
        tick();
      end
    end
    check("timeout_cycle_found", found, 1);
    check("restart_on_timeout_retry", status_retry_count, 0);
    check("restart_on_timeout_state", status_state, 0);

    // Stuck lane disabled: link comes up without it
    cfg_lanes_disable = 4'b0100;
    drive();
    pulse_restart();
    run_until(4, 600, "disabled_lane_data");
    check("disabled_link_up", link_up, 1);
    check("disabled_cgs_reset2", cgs_reset[2], 1);

    // One-cycle cgs_ready drop in DATA
    stuck = '0;
    cfg_lanes_disable = '0;
    drive();
    pulse_restart();
    run_until(4, 600, "drop_pre_data");
    drop = 4'b0001;
    drive();
    tick();
    drop = '0;
    drive();
    check("drop_state", status_state, 0);
    check("drop_link_up", link_up, 0);
    check("drop_retry", status_retry_count, 1);
    run_until(4, 600, "drop_rebringup");

    // Asynchronous reset between edges while in CGS
    pulse_restart();
    run_until(3, 600, "async_reach_cgs");
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("async");
    model_clear();
    tick();
    reset = 1'b0;

    // No timeout with a stuck lane
    cfg_timeout = '0;
    stuck = 4'b0100;
    drive();
    for (int k = 0; k < 400; k++) tick();
    check("no_timeout_state", status_state, 2);
    check("no_timeout_retry", status_retry_count, 0);

    // Randomized rounds against the model
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NL; i++) begin
        d_phy[i] = $urandom_range(1, 20);
        d_al[i]  = $urandom_range(1, 40);
        d_cgs[i] = $urandom_range(1, 40);
        stuck[i] = ($urandom_range(0, 5) == 0);
      end
      cfg_lanes_disable = NL'($urandom);
      cfg_timeout = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(20, 120));
      drive();
      pulse_restart();
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 299) == 0) cfg_enable = 1'b0;
        if ($urandom_range(0, 249) == 0) cfg_restart = 1'b1;
        if (status_state == 4 && $urandom_range(0, 59) == 0) drop = NL'(1 << $urandom_range(0, NL - 1));
        drive();
        tick();
        cfg_enable = 1'b1;
        cfg_restart = 1'b0;
        drop = '0;
        drive();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
